arbitro_selladora: RTL and testbench

ARBITRO_SELLADORA -- requirements
Module: arbitro_selladora

---
 rtl/arbitro_selladora_pkg.sv | 20 ++
 rtl/arbitro_selladora_temporizador.sv | 35 +++
 rtl/arbitro_selladora.sv | 164 ++++++++++++++++
 tb/tb_arbitro_selladora.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_selladora_pkg.sv
// Shared definitions for the selladora blocks: FSM state codes, the two
// accepted sock height codes, and default timing/fairness parameters.
package arbitro_selladora_pkg;

    localparam int SEAL_CYC_DEF = 8;   // sealing-enable length, cycles
    localparam int BATCH_DEF    = 4;   // max back-to-back services under contention

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_SEAL    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [2:0] TH_ALTO = 3'b101;
    localparam logic [2:0] TH_BAJO = 3'b010;

    function automatic logic th_valid(input logic [2:0] th);
        return (th == TH_ALTO) || (th == TH_BAJO);
    endfunction

endpackage

// File: rtl/arbitro_selladora_temporizador.sv
// temporizador_sellado: down-counter timing the SEAL phase.
//   clk, reset : clock, synchronous active-high reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value loaded; the phase lasts load_val+1 cycles
//   dec        : decrement while non-zero
//   zero       : counter is at zero (last cycle of the phase)
module temporizador_sellado #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/arbitro_selladora.sv
// arbitro_selladora: arbitrates one sealer between two sock lines
// (bit 0 = altos, bit 1 = bajos) and sequences IDLE->GRANT->SEAL->RELEASE.
//   clk, reset     : clock, synchronous active-high reset (highest priority)
//   REQ[1:0]       : level-sensitive seal requests
//   TH0/TH1[2:0]   : height code per line, sampled at the grant decision
//   STOP           : emergency stop, blocks grants / aborts a transaction
//   GNT[1:0]       : one-hot grant          EN   : sealer enable (SEAL only)
//   TSEL[2:0]      : height code to sealer  BUSY : not IDLE
//   DONE/ERR[1:0]  : one-cycle completion / rejection-or-abort pulses
// All outputs are registered.
module arbitro_selladora
    import arbitro_selladora_pkg::*;
#(
    parameter int SEAL_CYC = SEAL_CYC_DEF,
    parameter int BATCH    = BATCH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] REQ,
    input  logic [2:0] TH0,
    input  logic [2:0] TH1,
    input  logic       STOP,
    output logic [1:0] GNT,
    output logic       EN,
    output logic [2:0] TSEL,
    output logic [1:0] DONE,
    output logic [1:0] ERR,
    output logic       BUSY
);

    // Timer is loaded with SEAL_CYC-1 so that zero marks the final SEAL cycle.
    localparam logic [3:0] SEAL_LOAD = 4'(SEAL_CYC - 1);
    localparam logic [2:0] BATCH_L   = 3'(BATCH);

    logic [1:0] state_q, state_d;
    logic [1:0] gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic [2:0] tsel_q, tsel_d, cnt_q, cnt_d;
    logic       en_q, en_d, busy_q, busy_d;
    logic       last_q, last_d, win_q, win_d;
    logic       w;
    logic [2:0] th_w;
    logic       tmr_load, tmr_dec, tmr_zero;

    // Winner for the current IDLE cycle; under contention the last-served
    // line keeps the sealer until it has had BATCH consecutive services.
    always_comb begin
        w = 1'b0;
        case (REQ)
            2'b01:   w = 1'b0;
            2'b10:   w = 1'b1;
            2'b11:   w = (cnt_q < BATCH_L) ? last_q : ~last_q;
            default: w = 1'b0;
        endcase
        th_w = w ? TH1 : TH0;
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        en_d     = 1'b0;
        tsel_d   = tsel_q;
        done_d   = 2'b00;
        err_d    = 2'b00;
        last_d   = last_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        if (state_q != ST_IDLE && STOP) begin
            // Abort: drop everything, flag the line that owned the sealer.
            state_d      = ST_IDLE;
            gnt_d        = 2'b00;
            err_d[win_q] = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gnt_d = 2'b00;
                    if (!STOP && REQ != 2'b00) begin
                        // Rejected requests still count as services.
                        if (w == last_q) begin
                            if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
                        end else begin
                            last_d = w;
                            cnt_d  = 3'd1;
                        end
                        if (th_valid(th_w)) begin
                            state_d  = ST_GRANT;
                            gnt_d    = 2'b00;
                            gnt_d[w] = 1'b1;
                            tsel_d   = th_w;
                            win_d    = w;
                        end else begin
                            err_d[w] = 1'b1;
                        end
                    end
                end
                ST_GRANT: begin
                    state_d  = ST_SEAL;
                    en_d     = 1'b1;
                    tmr_load = 1'b1;
                end
                ST_SEAL: begin
                    if (tmr_zero) begin
                        state_d       = ST_RELEASE;
                        done_d[win_q] = 1'b1;
                    end else begin
                        en_d    = 1'b1;
                        tmr_dec = 1'b1;
                    end
                end
                default: begin // ST_RELEASE
                    state_d = ST_IDLE;
                    gnt_d   = 2'b00;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            en_q    <= 1'b0;
            tsel_q  <= 3'b000;
            done_q  <= 2'b00;
            err_q   <= 2'b00;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            cnt_q   <= 3'd0;
            win_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            en_q    <= en_d;
            tsel_q  <= tsel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
        end
    end

    temporizador_sellado #(.W(4)) u_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (SEAL_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign GNT  = gnt_q;
    assign EN   = en_q;
    assign TSEL = tsel_q;
    assign DONE = done_q;
    assign ERR  = err_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_arbitro_selladora.sv
// Scoreboard bench for arbitro_selladora: a transaction-level model pushes
// timestamped expected events (grant, done, error); a monitor pops them as
// the DUT shows them. Directed scenarios first, then random traffic.
module tb_arbitro_selladora;

    localparam int SEAL_CYC = 8;
    localparam int BATCH    = 4;
    localparam int K_GNT = 0, K_DONE = 1, K_ERR = 2;

    typedef struct {
        int         t;
        int         kind;
        logic [1:0] vec;
        logic [2:0] tsel;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [2:0] th0, th1;
    logic       stop;
    logic [1:0] gnt, done, err;
    logic       en, busy;
    logic [2:0] tsel;

    int  cyc = 0;
    int  tests = 0, fails = 0;
    bit  mon_on = 0;
    ev_t sbq[$];
    int  glog[$];
    int  hist[$];
    bit  m_active = 0;
    int  m_t = 0, m_line = 0;
    int  en_cnt = 0;
    logic [1:0] gnt_prev = 2'b00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arbitro_selladora #(.SEAL_CYC(SEAL_CYC), .BATCH(BATCH)) dut (
        .clk(clk), .reset(reset), .REQ(req), .TH0(th0), .TH1(th1), .STOP(stop),
        .GNT(gnt), .EN(en), .TSEL(tsel), .DONE(done), .ERR(err), .BUSY(busy)
    );

    function automatic void chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endfunction

    function automatic void push_ev(int t, int kind, int line, logic [2:0] ts);
        ev_t e;
        e.t = t; e.kind = kind; e.vec = (line == 1) ? 2'b10 : 2'b01; e.tsel = ts;
        sbq.push_back(e);
    endfunction

    // Length of the trailing run of identical lines in the service history.
    function automatic int run_len();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] == hist[hist.size()-1]) n++;
            else break;
        end
        return n;
    endfunction

    // Reference model for the inputs present during cycle c (effects at c+1).
    function automatic void model(int c, logic [1:0] r, logic [2:0] a, logic [2:0] b,
                                  logic s, logic rs);
        int w, last, run;
        logic [2:0] th;
        if (rs) begin
            m_active = 0;
            hist.delete();
            return;
        end
        if (m_active) begin
            if (s) begin
                push_ev(c + 1, K_ERR, m_line, 3'b000);
                m_active = 0;
            end else if (c == m_t + 1 + SEAL_CYC) begin
                push_ev(c + 1, K_DONE, m_line, 3'b000);
            end else if (c == m_t + 2 + SEAL_CYC) begin
                m_active = 0;
            end
            return;
        end
        if (s || r == 2'b00) return;
        last = (hist.size() == 0) ? 0 : hist[hist.size()-1];
        run  = (hist.size() == 0) ? 0 : run_len();
        if (r == 2'b01)      w = 0;
        else if (r == 2'b10) w = 1;
        else                 w = (run < BATCH) ? last : 1 - last;
        hist.push_back(w);
        th = (w == 1) ? b : a;
        if (th == 3'b101 || th == 3'b010) begin
            push_ev(c + 1, K_GNT, w, th);
            m_active = 1; m_t = c; m_line = w;
        end else begin
            push_ev(c + 1, K_ERR, w, 3'b000);
        end
    endfunction

    task automatic step(input logic [1:0] r, input logic [2:0] a, input logic [2:0] b,
                        input logic s, input logic rs);
        @(posedge clk); #1;
        req = r; th0 = a; th1 = b; stop = s; reset = rs;
        model(cyc, r, a, b, s, rs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 3'b101, 3'b010, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(2'b00, 3'b000, 3'b000, 1'b0, 1'b1);
        step(2'b00, 3'b000, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        chk("reset_outputs_zero", int'({gnt, en, tsel, done, err, busy}), 0);
        glog.delete();
    endtask

    task automatic check_glog(input string name, input int n, input logic [15:0] lines);
        chk({name, "_grant_count"}, glog.size(), n);
        for (int i = 0; i < n && i < glog.size(); i++)
            chk({name, "_grant_line"}, glog[i], int'(lines[i]));
    endtask

    task automatic observe(input int kind, input logic [1:0] vec, input logic [2:0] ts);
        ev_t e;
        if (sbq.size() == 0) begin
            chk("unexpected_event_kind", kind, -1);
            return;
        end
        e = sbq.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.t);
        chk("event_line", int'(vec), int'(e.vec));
        if (kind == K_GNT) chk("tsel", int'(ts), int'(e.tsel));
    endtask

    task automatic mon_cycle();
        while (sbq.size() != 0 && sbq[0].t < cyc) begin
            chk("missed_event_kind", -1, sbq[0].kind);
            void'(sbq.pop_front());
        end
        chk("gnt_not_both", int'(gnt == 2'b11), 0);
        chk("en_without_gnt", int'(en && gnt == 2'b00), 0);
        chk("busy_vs_gnt", int'(busy), int'(gnt != 2'b00));
        if (gnt != 2'b00 && gnt_prev == 2'b00) begin
            observe(K_GNT, gnt, tsel);
            glog.push_back(int'(gnt[1]));
            en_cnt = 0;
        end
        if (done != 2'b00) begin
            observe(K_DONE, done, 3'b000);
            chk("en_cycles", en_cnt, SEAL_CYC);
        end
        if (err != 2'b00) observe(K_ERR, err, 3'b000);
        if (en) en_cnt++;
        gnt_prev = gnt;
    endtask

    function automatic logic [2:0] rnd_th();
        int k = $urandom_range(0, 19);
        if (k < 8)  return 3'b101;
        if (k < 16) return 3'b010;
        return 3'($urandom_range(0, 7));
    endfunction

    initial begin
        reset = 1'b1; req = 2'b00; th0 = 3'b000; th1 = 3'b000; stop = 1'b0;
        repeat (2) @(posedge clk);
        fork
            begin
                forever begin
                    @(negedge clk);
                    if (mon_on) mon_cycle();
                end
            end
            begin
                mon_on = 1;
                // Single line-0 transaction, timing of the whole cycle.
                do_reset();
                step(2'b01, 3'b101, 3'b010, 1'b0, 1'b0);
                idle(11);
                @(negedge clk);
                chk("busy_after_release", int'({busy, en, gnt}), 0);

                // Both lines requesting: BATCH-limited alternation.
                do_reset();
                for (int i = 0; i < 9 * (SEAL_CYC + 3); i++)
                    step(2'b11, 3'b101, 3'b010, 1'b0, 1'b0);
                idle(3);
                check_glog("batch", 9, 16'h00F0);

                // Rejected code counts as a service and tips the batch to line 0.
                do_reset();
                for (int i = 0; i < 3 * (SEAL_CYC + 3); i++)
                    step(2'b10, 3'b101, 3'b010, 1'b0, 1'b0);
                step(2'b10, 3'b101, 3'b111, 1'b0, 1'b0);
                idle(1);
                for (int i = 0; i < SEAL_CYC + 3; i++)
                    step(2'b11, 3'b101, 3'b010, 1'b0, 1'b0);
                idle(3);
                check_glog("reject", 4, 16'h0007);

                // STOP in the 4th SEAL cycle of line 1, then held.
                do_reset();
                step(2'b10, 3'b101, 3'b010, 1'b0, 1'b0);
                idle(4);
                step(2'b00, 3'b101, 3'b010, 1'b1, 1'b0);
                step(2'b11, 3'b101, 3'b010, 1'b1, 1'b0);
                @(negedge clk);
                chk("stop_abort_outputs", int'({gnt, en, done, err}), 7'b00_0_00_10);
                for (int i = 0; i < 14; i++) step(2'b11, 3'b101, 3'b010, 1'b1, 1'b0);
                idle(2);
                check_glog("stop", 1, 16'h0001);

                // Reset mid-SEAL with STOP, history must restart at line 0.
                do_reset();
                step(2'b10, 3'b101, 3'b010, 1'b0, 1'b0);
                idle(3);
                step(2'b11, 3'b101, 3'b010, 1'b1, 1'b1);
                step(2'b00, 3'b101, 3'b010, 1'b0, 1'b0);
                @(negedge clk);
                chk("reset_mid_seal_zero", int'({gnt, en, tsel, done, err, busy}), 0);
                for (int i = 0; i < SEAL_CYC + 3; i++)
                    step(2'b11, 3'b101, 3'b010, 1'b0, 1'b0);
                idle(3);
                check_glog("post_reset", 2, 16'h0001);

                // Random traffic.
                for (int i = 0; i < 3000; i++)
                    step(2'($urandom_range(0, 3)), rnd_th(), rnd_th(),
                         ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0));
                idle(SEAL_CYC + 6);
                @(negedge clk);
                chk("scoreboard_drained", sbq.size(), 0);
            end
        join_any
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
